// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue and its FIFO.
package fetch_queue_pkg;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetchq_entry_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_data_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Show-ahead FIFO holding fetched instructions; head is valid whenever empty is low.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetchq_entry_t wdata,
  output fetchq_entry_t head,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetchq_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential ibus requests, one outstanding, buffered
// in a show-ahead FIFO; a branch redirects the PC, flushes and drops in-flight data.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch,
  input  logic [63:0] jump,
  input  logic        stop,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output fetch_data_t dataF
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          push, pop, credit, empty;
  logic [CW-1:0] count, count_after;
  fetchq_entry_t head, wdata;
  logic          unused_jump;

  assign unused_jump = ^jump[1:0];

  // Credit: a request may only be raised if the FIFO will still have a free slot after this edge.
  always_comb begin
    push        = (state_q == WAIT) && iresp.data_ok && !branch;
    pop         = !empty && !stop && !branch;
    count_after = count;
    if (branch)             count_after = '0;
    else if (push && !pop)  count_after = count + CW'(1);
    else if (!push && pop)  count_after = count - CW'(1);
    credit = (count_after < CW'(DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    wdata.instr = iresp.data;
    wdata.pc    = addr_q;
    if (branch) pc_d = {jump[63:2], 2'b00};
    case (state_q)
      IDLE: begin
        if (!branch && credit) begin
          state_d = WAIT;
          valid_d = 1'b1;
          addr_d  = pc_q;
        end
      end
      WAIT: begin
        if (iresp.data_ok) begin
          if (branch) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            pc_d = addr_q + 64'd4;
            if (credit) begin
              addr_d = addr_q + 64'd4;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end
        end else if (branch) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (iresp.data_ok) begin
          if (branch || !credit) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = WAIT;
            addr_d  = pc_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (branch),
    .wdata (wdata),
    .head  (head),
    .empty (empty),
    .count (count)
  );

  assign ireq.valid  = valid_q;
  assign ireq.addr   = addr_q;
  assign dataF.valid = !empty;
  assign dataF.instr = head.instr;
  assign dataF.pc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios on DEPTH=4 plus randomized
// runs on DEPTH 2/4/8 checked against a bus/queue reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_s [ND];
  logic [63:0] jump_s   [ND];
  logic        stop_s   [ND];
  ibus_resp_t  iresp_s  [ND];
  ibus_req_t   ireq_s   [ND];
  fetch_data_t dataf_s  [ND];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_queue #(.RESET_PC(RST_PC), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .branch(branch_s[0]), .jump(jump_s[0]), .stop(stop_s[0]),
    .ireq(ireq_s[0]), .iresp(iresp_s[0]), .dataF(dataf_s[0]));

  fetch_queue #(.RESET_PC(RST_PC), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .branch(branch_s[1]), .jump(jump_s[1]), .stop(stop_s[1]),
    .ireq(ireq_s[1]), .iresp(iresp_s[1]), .dataF(dataf_s[1]));

  fetch_queue #(.RESET_PC(RST_PC), .DEPTH(8)) u_d8 (
    .clk(clk), .reset(reset), .branch(branch_s[2]), .jump(jump_s[2]), .stop(stop_s[2]),
    .ireq(ireq_s[2]), .iresp(iresp_s[2]), .dataF(dataf_s[2]));

  // The bus returns an instruction word derived from its address so pushes can be traced.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) iresp_s[d].data = instr_of(ireq_s[d].addr);
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < ND; d++) begin
      branch_s[d]        = 1'b0;
      jump_s[d]          = 64'd0;
      stop_s[d]          = 1'b0;
      iresp_s[d].data_ok = 1'b0;
      iresp_s[d].data    = 32'd0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int d = 0; d < ND; d++) iresp_s[d].data = instr_of(ireq_s[d].addr);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (ireq_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ireq_valid: got %b want 0", ireq_s[0].valid);
    end
    n_tests++;
    if (ireq_s[0].addr !== RST_PC) begin
      n_fail++;
      $display("[TB] FAIL reset_ireq_addr: got %h want %h", ireq_s[0].addr, RST_PC);
    end
    n_tests++;
    if (dataf_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_dataf_valid: got %b want 0", dataf_s[0].valid);
    end
  endtask

  task automatic test_stream();
    logic [63:0] want;
    do_reset();
    iresp_s[0].data_ok = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      want = RST_PC + 64'(4 * (c - 1));
      n_tests++;
      if (ireq_s[0].valid !== 1'b1 || ireq_s[0].addr !== want) begin
        n_fail++;
        $display("[TB] FAIL stream_ireq c=%0d: got v=%b addr=%h want v=1 addr=%h",
                 c, ireq_s[0].valid, ireq_s[0].addr, want);
      end
      if (c >= 2) begin
        want = RST_PC + 64'(4 * (c - 2));
        n_tests++;
        if (dataf_s[0].valid !== 1'b1 || dataf_s[0].pc !== want ||
            dataf_s[0].instr !== instr_of(want)) begin
          n_fail++;
          $display("[TB] FAIL stream_dataf c=%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                   c, dataf_s[0].valid, dataf_s[0].pc, dataf_s[0].instr, want, instr_of(want));
        end
      end
    end
  endtask

  task automatic test_stop();
    int accepted;
    logic [63:0] want;
    do_reset();
    iresp_s[0].data_ok = 1'b1;
    stop_s[0] = 1'b1;
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      if (ireq_s[0].valid === 1'b1) accepted++;
      step();
    end
    n_tests++;
    if (accepted != 4) begin
      n_fail++;
      $display("[TB] FAIL stop_accepted: got %0d want 4", accepted);
    end
    n_tests++;
    if (ireq_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stop_ireq_idle: got %b want 0", ireq_s[0].valid);
    end
    stop_s[0] = 1'b0;
    want = RST_PC;
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (dataf_s[0].valid !== 1'b1 || dataf_s[0].pc !== want ||
          dataf_s[0].instr !== instr_of(want)) begin
        n_fail++;
        $display("[TB] FAIL stop_drain i=%0d: got v=%b pc=%h want v=1 pc=%h",
                 i, dataf_s[0].valid, dataf_s[0].pc, want);
      end
      step();
      want = want + 64'd4;
    end
  endtask

  task automatic test_branch_drop();
    do_reset();
    iresp_s[0].data_ok = 1'b1;
    repeat (3) step();
    n_tests++;
    if (ireq_s[0].valid !== 1'b1 || ireq_s[0].addr !== RST_PC + 64'd8) begin
      n_fail++;
      $display("[TB] FAIL drop_setup: got v=%b addr=%h want v=1 addr=%h",
               ireq_s[0].valid, ireq_s[0].addr, RST_PC + 64'd8);
    end
    iresp_s[0].data_ok = 1'b0;
    branch_s[0] = 1'b1;
    jump_s[0]   = RST_PC + 64'h100;
    step();
    branch_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ireq_s[0].valid !== 1'b1 || ireq_s[0].addr !== RST_PC + 64'd8 ||
          dataf_s[0].valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL drop_hold i=%0d: got v=%b addr=%h dv=%b want v=1 addr=%h dv=0",
                 i, ireq_s[0].valid, ireq_s[0].addr, dataf_s[0].valid, RST_PC + 64'd8);
      end
      if (i < 2) step();
    end
    iresp_s[0].data_ok = 1'b1;
    step();
    n_tests++;
    if (ireq_s[0].valid !== 1'b1 || ireq_s[0].addr !== RST_PC + 64'h100 ||
        dataf_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL drop_reissue: got v=%b addr=%h dv=%b want v=1 addr=%h dv=0",
               ireq_s[0].valid, ireq_s[0].addr, dataf_s[0].valid, RST_PC + 64'h100);
    end
    step();
    n_tests++;
    if (dataf_s[0].valid !== 1'b1 || dataf_s[0].pc !== RST_PC + 64'h100 ||
        dataf_s[0].instr !== instr_of(RST_PC + 64'h100)) begin
      n_fail++;
      $display("[TB] FAIL drop_first_pc: got v=%b pc=%h want v=1 pc=%h",
               dataf_s[0].valid, dataf_s[0].pc, RST_PC + 64'h100);
    end
  endtask

  task automatic test_branch_dok();
    logic [63:0] tgt;
    tgt = RST_PC + 64'h2000;
    do_reset();
    iresp_s[0].data_ok = 1'b1;
    repeat (3) step();
    n_tests++;
    if (dataf_s[0].valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bdok_setup: got dv=%b want 1", dataf_s[0].valid);
    end
    branch_s[0] = 1'b1;
    jump_s[0]   = tgt;
    step();
    branch_s[0] = 1'b0;
    n_tests++;
    if (dataf_s[0].valid !== 1'b0 || ireq_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bdok_flush: got dv=%b rv=%b want dv=0 rv=0",
               dataf_s[0].valid, ireq_s[0].valid);
    end
    step();
    n_tests++;
    if (ireq_s[0].valid !== 1'b1 || ireq_s[0].addr !== tgt || dataf_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bdok_reissue: got v=%b addr=%h dv=%b want v=1 addr=%h dv=0",
               ireq_s[0].valid, ireq_s[0].addr, dataf_s[0].valid, tgt);
    end
    step();
    n_tests++;
    if (dataf_s[0].valid !== 1'b1 || dataf_s[0].pc !== tgt) begin
      n_fail++;
      $display("[TB] FAIL bdok_first_pc: got v=%b pc=%h want v=1 pc=%h",
               dataf_s[0].valid, dataf_s[0].pc, tgt);
    end
  endtask

  task automatic test_jump_unaligned();
    do_reset();
    iresp_s[0].data_ok = 1'b1;
    branch_s[0] = 1'b1;
    jump_s[0]   = 64'h8000_0102;
    step();
    branch_s[0] = 1'b0;
    n_tests++;
    if (ireq_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unaligned_no_issue: got v=%b want 0", ireq_s[0].valid);
    end
    step();
    n_tests++;
    if (ireq_s[0].valid !== 1'b1 || ireq_s[0].addr !== 64'h8000_0100) begin
      n_fail++;
      $display("[TB] FAIL unaligned_addr: got v=%b addr=%h want v=1 addr=%h",
               ireq_s[0].valid, ireq_s[0].addr, 64'h8000_0100);
    end
    step();
    n_tests++;
    if (dataf_s[0].valid !== 1'b1 || dataf_s[0].pc !== 64'h8000_0100) begin
      n_fail++;
      $display("[TB] FAIL unaligned_pc: got v=%b pc=%h want v=1 pc=%h",
               dataf_s[0].valid, dataf_s[0].pc, 64'h8000_0100);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    iresp_s[0].data_ok = 1'b1;
    stop_s[0] = 1'b1;
    repeat (3) step();
    iresp_s[0].data_ok = 1'b0;
    step();
    n_tests++;
    if (ireq_s[0].valid !== 1'b1 || ireq_s[0].addr !== RST_PC + 64'd8 ||
        dataf_s[0].valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midwait_setup: got v=%b addr=%h dv=%b want v=1 addr=%h dv=1",
               ireq_s[0].valid, ireq_s[0].addr, dataf_s[0].valid, RST_PC + 64'd8);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (ireq_s[0].valid !== 1'b0 || ireq_s[0].addr !== RST_PC || dataf_s[0].valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midwait_reset: got v=%b addr=%h dv=%b want v=0 addr=%h dv=0",
               ireq_s[0].valid, ireq_s[0].addr, dataf_s[0].valid, RST_PC);
    end
  endtask

  // Model: the bench plays the bus (random latency) and tracks queue occupancy, the PC
  // expected at the head and the address the next request must carry.
  task automatic test_random(input int d, input int depth, input int cycles);
    int          occ, cd;
    bit          pend, drop, b, s, k, pop;
    logic [63:0] exp_pc, req_exp, paddr, j;
    do_reset();
    occ = 0; cd = 0; pend = 0; drop = 0;
    exp_pc = RST_PC; req_exp = RST_PC; paddr = RST_PC;
    for (int c = 0; c < cycles; c++) begin
      b = ($urandom_range(0, 99) < 8);
      s = ($urandom_range(0, 99) < 35);
      j = {32'd0, 32'h8000_0000 | ($urandom & 32'h000f_ffff)};
      k = pend && (cd == 0);
      if (pend && cd > 0) cd--;
      branch_s[d]        = b;
      jump_s[d]          = j;
      stop_s[d]          = s;
      iresp_s[d].data_ok = k;
      iresp_s[d].data    = instr_of(paddr);
      pop = (occ > 0) && !s && !b;
      step();
      iresp_s[d].data = instr_of(paddr);
      if (pend && k) begin
        if (!drop && !b) begin
          occ++;
          req_exp = req_exp + 64'd4;
        end
        pend = 0;
        drop = 0;
      end
      if (b) begin
        occ     = 0;
        exp_pc  = {j[63:2], 2'b00};
        req_exp = {j[63:2], 2'b00};
        if (pend) drop = 1;
      end else if (pop) begin
        occ--;
        exp_pc = exp_pc + 64'd4;
      end
      n_tests++;
      if (dataf_s[d].valid !== (occ > 0) || occ > depth) begin
        n_fail++;
        $display("[TB] FAIL rand_occupancy d=%0d c=%0d: got dv=%b want dv=%b (model count %0d, depth %0d)",
                 d, c, dataf_s[d].valid, (occ > 0), occ, depth);
      end
      if (occ > 0) begin
        n_tests++;
        if (dataf_s[d].pc !== exp_pc || dataf_s[d].instr !== instr_of(exp_pc)) begin
          n_fail++;
          $display("[TB] FAIL rand_head d=%0d c=%0d: got pc=%h instr=%h want pc=%h instr=%h",
                   d, c, dataf_s[d].pc, dataf_s[d].instr, exp_pc, instr_of(exp_pc));
        end
      end
      if (pend) begin
        n_tests++;
        if (ireq_s[d].valid !== 1'b1 || ireq_s[d].addr !== paddr) begin
          n_fail++;
          $display("[TB] FAIL rand_req_stable d=%0d c=%0d: got v=%b addr=%h want v=1 addr=%h",
                   d, c, ireq_s[d].valid, ireq_s[d].addr, paddr);
        end
      end else if (ireq_s[d].valid === 1'b1) begin
        n_tests++;
        if (b || ireq_s[d].addr !== req_exp) begin
          n_fail++;
          $display("[TB] FAIL rand_issue d=%0d c=%0d: got addr=%h branch_edge=%b want addr=%h branch_edge=0",
                   d, c, ireq_s[d].addr, b, req_exp);
        end
        pend  = 1;
        paddr = ireq_s[d].addr;
        cd    = $urandom_range(0, 5);
      end
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_stream();
    test_stop();
    test_branch_drop();
    test_branch_dok();
    test_jump_unaligned();
    test_reset_mid_wait();
    test_random(1, 2, 400);
    test_random(2, 8, 400);
    test_random(0, 4, 300);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
